// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for both ends of the layer-sort handshake.
// It holds the frame constants, the bit positions of each frame field, the
// responder state enum and a few 4-bit helpers.
// The initiator side imports this same package.
// -----------------------------------------------------------------------------
package sort_pkg;

   localparam logic [15:0] SYNC    = 16'hBEEF;
   localparam logic [3:0]  HDR_REQ = 4'hA;
   localparam logic [3:0]  HDR_ACK = 4'h5;

   // frame layout: HDR | PWR | SRC_ID | DST_ID | SYNC
   localparam int HDR_MSB    = 31;
   localparam int HDR_LSB    = 28;
   localparam int PWR_MSB    = 27;
   localparam int PWR_LSB    = 24;
   localparam int SRC_MSB    = 23;
   localparam int SRC_LSB    = 20;
   localparam int DST_MSB    = 19;
   localparam int DST_LSB    = 16;
   localparam int SYNC_MSB   = 15;
   localparam int SYNC_LSB   = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LISTEN,
      ST_QUAL,
      ST_ACK,
      ST_DONE,
      ST_FAULT
   } sort_state_e;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
      return (a > b) ? a : b;
   endfunction

   // The acknowledge frame carries our ID as source and ID+1 (mod 16) as
   // destination, so it passes the same consistency rule as a request.
   function automatic logic [31:0] ack_frame(input logic [3:0] pwr, input logic [3:0] id);
      logic [3:0] id_nxt;
      id_nxt = id + 4'd1;
      return {HDR_ACK, pwr, id, id_nxt, SYNC};
   endfunction

endpackage

// File: rtl/sort_frame_decode.sv
// -----------------------------------------------------------------------------
// sort_frame_decode
// Purely combinational check of a received frame: the request header, the
// sync word, and DST_ID == SRC_ID + 1 (4-bit wrap).
// Ports:
//   frame_i   [31:0]  received inter-die word
//   valid_o           frame is a well-formed sort request
//   src_id_o  [3:0]   sender ID field
//   dst_id_o  [3:0]   candidate ID field
//   pwr_o     [3:0]   power field
// -----------------------------------------------------------------------------
module sort_frame_decode
   import sort_pkg::*;
(
   input  logic [31:0] frame_i,
   output logic        valid_o,
   output logic [3:0]  src_id_o,
   output logic [3:0]  dst_id_o,
   output logic [3:0]  pwr_o
);

   logic [3:0] src_nxt;

   assign src_id_o = frame_i[SRC_MSB:SRC_LSB];
   assign dst_id_o = frame_i[DST_MSB:DST_LSB];
   assign pwr_o    = frame_i[PWR_MSB:PWR_LSB];
   assign src_nxt  = src_id_o + 4'd1;

   assign valid_o = (frame_i[HDR_MSB:HDR_LSB] == HDR_REQ) &&
                    (frame_i[SYNC_MSB:SYNC_LSB] == SYNC) &&
                    (dst_id_o == src_nxt);

endmodule

// File: rtl/sort_responder.sv
// -----------------------------------------------------------------------------
// sort_responder
// Upper-die end of the layer-sort handshake. The block qualifies request
// frames from the die below and adopts the carried chip ID. It then drives an
// acknowledge frame, re-acknowledges retransmissions, and flags illegal IDs.
// Optional build macro SORT_RESP_TIMEOUT_EN adds a LISTEN watchdog. After
// TIMEOUT_CYCLES cycles in LISTEN with no valid request, the block raises
// id_err and goes to FAULT.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           responder enable (ignored once in DONE/FAULT)
//   data_in      inter-die receive bus
//   data_out     inter-die transmit bus, zero unless acknowledging
//   tx_out       high while an ack frame is on data_out
//   chip_id      adopted ID
//   id_valid     ID has been adopted
//   pwr_level    highest power field seen at accept / re-accept
//   id_err       sticky error: illegal ID, re-ack limit, or watchdog
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | disabled, waiting for en
// ST_LISTEN | waiting for a valid request frame
// ST_QUAL   | counting consecutive identical requests
// ST_ACK    | ack frame on the bus (output lags state by one cycle)
// ST_DONE   | ID adopted, watching for retransmissions
// ST_FAULT  | terminal error, only reset leaves
// -----------------------------------------------------------------------------
module sort_responder
   import sort_pkg::*;
#(
   parameter int unsigned MATCH_CYCLES   = 2,
   parameter int unsigned ACK_CYCLES     = 4,
   parameter int unsigned MAX_REACK      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        tx_out,
   output logic [3:0]  chip_id,
   output logic        id_valid,
   output logic [3:0]  pwr_level,
   output logic        id_err
);

   localparam logic [3:0] MATCH_N   = 4'(MATCH_CYCLES);
   localparam logic [3:0] ACK_LOAD  = 4'(ACK_CYCLES - 1);
   localparam logic [3:0] REACK_MAX = 4'(MAX_REACK);

   logic       req_valid;
   logic [3:0] req_src, req_dst, req_pwr;
   logic [7:0] req_key;

   sort_frame_decode u_decode (
      .frame_i  (data_in),
      .valid_o  (req_valid),
      .src_id_o (req_src),
      .dst_id_o (req_dst),
      .pwr_o    (req_pwr)
   );

   assign req_key = {req_src, req_dst};

   sort_state_e state_q, state_d;
   logic [7:0]  key_q, key_d;
   logic [3:0]  match_q, match_d;
   logic [3:0]  pwr_cap_q, pwr_cap_d;
   logic [3:0]  ack_cnt_q, ack_cnt_d;
   logic [3:0]  reack_q, reack_d;
   logic [3:0]  chip_q, chip_d;
   logic        idv_q, idv_d;
   logic [3:0]  pwr_lvl_q, pwr_lvl_d;
   logic        err_q, err_d;
   logic        tx_q, tx_d;
   logic [31:0] dout_q, dout_d;
   logic        accept;
   logic [3:0]  match_inc;
   logic [3:0]  pwr_max;

`ifdef SORT_RESP_TIMEOUT_EN
   localparam logic [15:0] WD_LOAD = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_q, wd_d;
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = TIMEOUT_CYCLES;
`endif

   assign match_inc = sat_inc4(match_q);
   assign pwr_max   = max4(pwr_cap_q, req_pwr);

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      match_d   = match_q;
      pwr_cap_d = pwr_cap_q;
      ack_cnt_d = ack_cnt_q;
      reack_d   = reack_q;
      chip_d    = chip_q;
      idv_d     = idv_q;
      pwr_lvl_d = pwr_lvl_q;
      err_d     = err_q;
      accept    = 1'b0;
`ifdef SORT_RESP_TIMEOUT_EN
      wd_d      = WD_LOAD;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LISTEN;
         end
         ST_LISTEN: begin
            if (req_valid) begin
               key_d     = req_key;
               match_d   = 4'd1;
               pwr_cap_d = req_pwr;
               state_d   = ST_QUAL;
               accept    = (4'd1 >= MATCH_N);
            end
`ifdef SORT_RESP_TIMEOUT_EN
            else if (wd_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_FAULT;
            end else begin
               wd_d = wd_q - 16'd1;
            end
`endif
         end
         ST_QUAL: begin
            if (!req_valid) begin
               match_d = '0;
               state_d = ST_LISTEN;
            end else if (req_key == key_q) begin
               match_d   = match_inc;
               pwr_cap_d = pwr_max;
               accept    = (match_inc >= MATCH_N);
            end else begin
               // a changed key restarts qualification on the new frame
               key_d     = req_key;
               match_d   = 4'd1;
               pwr_cap_d = req_pwr;
               accept    = (4'd1 >= MATCH_N);
            end
         end
         ST_ACK: begin
            if (ack_cnt_q == '0) state_d = ST_DONE;
            else                 ack_cnt_d = ack_cnt_q - 4'd1;
         end
         ST_DONE: begin
            if (req_valid && (req_dst == chip_q)) begin
               if (reack_q >= REACK_MAX) begin
                  err_d   = 1'b1;
                  state_d = ST_FAULT;
               end else begin
                  reack_d   = sat_inc4(reack_q);
                  pwr_lvl_d = max4(pwr_lvl_q, req_pwr);
                  ack_cnt_d = ACK_LOAD;
                  state_d   = ST_ACK;
               end
            end
         end
         ST_FAULT: ;
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         match_d = '0;
         // ID 0 only arises when the sender sits at 4'hF and wrapped
         if (req_dst == 4'd0) begin
            err_d   = 1'b1;
            state_d = ST_FAULT;
         end else begin
            chip_d    = req_dst;
            idv_d     = 1'b1;
            pwr_lvl_d = pwr_cap_d;
            reack_d   = '0;
            ack_cnt_d = ACK_LOAD;
            state_d   = ST_ACK;
         end
      end

      if (!en && (state_q != ST_DONE) && (state_q != ST_FAULT)) begin
         state_d   = ST_IDLE;
         key_d     = '0;
         match_d   = '0;
         pwr_cap_d = '0;
         ack_cnt_d = '0;
         reack_d   = '0;
         chip_d    = '0;
         idv_d     = 1'b0;
         pwr_lvl_d = '0;
      end
   end

   // Transmit side follows the current state, so the ack lags the entry into
   // ACK by one cycle. Gating with en makes a mid-ACK disable clear the bus
   // together with the state.
   assign tx_d   = (state_q == ST_ACK) && en;
   assign dout_d = tx_d ? ack_frame(pwr_lvl_q, chip_q) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         key_q     <= '0;
         match_q   <= '0;
         pwr_cap_q <= '0;
         ack_cnt_q <= '0;
         reack_q   <= '0;
         chip_q    <= '0;
         idv_q     <= 1'b0;
         pwr_lvl_q <= '0;
         err_q     <= 1'b0;
         tx_q      <= 1'b0;
         dout_q    <= '0;
`ifdef SORT_RESP_TIMEOUT_EN
         wd_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         match_q   <= match_d;
         pwr_cap_q <= pwr_cap_d;
         ack_cnt_q <= ack_cnt_d;
         reack_q   <= reack_d;
         chip_q    <= chip_d;
         idv_q     <= idv_d;
         pwr_lvl_q <= pwr_lvl_d;
         err_q     <= err_d;
         tx_q      <= tx_d;
         dout_q    <= dout_d;
`ifdef SORT_RESP_TIMEOUT_EN
         wd_q      <= wd_d;
`endif
      end
   end

   assign data_out  = dout_q;
   assign tx_out    = tx_q;
   assign chip_id   = chip_q;
   assign id_valid  = idv_q;
   assign pwr_level = pwr_lvl_q;
   assign id_err    = err_q;

endmodule

// File: doc/sort_responder.md
Name: sort_responder

Overview:
- Upper-die end of the layer-sort handshake in the 3D stack.
- Listens on the inter-die data bus for sort request frames from the die below and adopts the chip ID carried in the frame.
- Replies with an acknowledge frame whose fields satisfy the initiator's ack check: sync word, and own ID in bits [23:20].
- Re-acknowledges retransmitted requests, and flags illegal IDs.

Parameters:
- SYNC, 16'hBEEF, sync word in bits [15:0] of every frame.
- HDR_REQ, 4'hA, header nibble of a request frame.
- HDR_ACK, 4'h5, header nibble of an acknowledge frame.
- MATCH_CYCLES, 2, consecutive identical valid request cycles required before accepting (range 1..15).
- ACK_CYCLES, 4, cycles the ack frame is driven (range 1..15).
- MAX_REACK, 3, re-acknowledgements allowed after the first ack before FAULT.
- TIMEOUT_CYCLES, 1000, LISTEN watchdog limit (feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  responder enable; low holds the block in IDLE
- data_in  in  32  inter-die receive bus
- data_out  out  32  inter-die transmit bus; zero when not acknowledging
- tx_out  out  1  high while an ack frame is on data_out
- chip_id  out  4  adopted ID; 0 until adopted
- id_valid  out  1  high once an ID is adopted (DONE/ACK after first accept)
- pwr_level  out  4  highest request power field [27:24] seen at accept/re-accept
- id_err  out  1  sticky: illegal ID or re-ack limit exceeded

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; all outputs 0; all counters 0.
- Valid request: all of the following hold.
  - data_in[31:28]==HDR_REQ
  - data_in[15:0]==SYNC
  - data_in[19:16]==data_in[23:20]+1 (4-bit wrap)
- Candidate ID is data_in[19:16].
- IDLE: go to LISTEN when en=1.
- LISTEN:
  - On a valid request, latch data_in[23:16] as the candidate key, set match_cnt=1, go to QUAL.
  - If MATCH_CYCLES==1, treat this cycle as the completing cycle of QUAL.
- QUAL, each cycle:
  - Valid request with the same key: match_cnt++ and capture max(power).
  - Valid request with a different key: reload the key, match_cnt=1.
  - Invalid request: back to LISTEN.
- QUAL completion, when match_cnt reaches MATCH_CYCLES:
  - Candidate ID==0 (sender at 4'hF wrapped): id_err=1, go to FAULT.
  - Otherwise: chip_id=candidate, id_valid=1, pwr_level=captured power, go to ACK.
- ACK:
  - tx_out=1 for exactly ACK_CYCLES cycles.
  - data_out={HDR_ACK, pwr_level, chip_id, chip_id+1, SYNC}.
  - Then go to DONE with data_out=0.
  - data_out is registered: the ack appears the cycle after entering ACK and is removed the cycle after leaving ACK.
- DONE:
  - A valid request whose candidate ID equals chip_id is a retransmission (initiator missed the ack).
  - On a retransmission: reack_cnt++, update pwr_level to max, go to ACK.
  - If reack_cnt already equals MAX_REACK: id_err=1, go to FAULT instead.
  - Requests carrying a different ID are ignored; chip_id never changes after adoption.
- FAULT: terminal; tx_out=0; chip_id and id_valid hold their values.
- en deasserted in any state except DONE/FAULT:
  - Next state IDLE; chip_id, id_valid, pwr_level cleared; tx_out=0.
- en deasserted in DONE/FAULT: ignored.
- Arithmetic: 4-bit modulo for ID+1; counters saturate, never wrap.
- Single-cycle glitch frames never reach ACK when MATCH_CYCLES>=2.

Optional Feature:
- Macro: SORT_RESP_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in LISTEN.
  - At TIMEOUT_CYCLES without any valid request: id_err=1, go to FAULT.
  - The watchdog clears when leaving LISTEN.
- Undefined:
  - No watchdog; LISTEN waits indefinitely.
  - TIMEOUT_CYCLES unused.

Decomposition:
- Shared package sort_pkg holds:
  - SYNC, HDR_REQ and HDR_ACK constants.
  - Frame field bit positions (HDR 31:28, PWR 27:24, SRC_ID 23:20, DST_ID 19:16, SYNC 15:0).
  - State enum.
- The initiator side imports the same package.
- One sub-module, sort_frame_decode: combinational header/sync/ID-consistency check producing valid, src_id, dst_id, pwr.

Test Plan:
- Reset, en=1, data_in=32'hA3_34_BEEF held 2 cycles -> ACK entered; data_out=32'h5_3_4_5_BEEF for 4 cycles, tx_out=1; chip_id=4, id_valid=1, pwr_level=3.
- Single-cycle 32'hA1_12_BEEF between zeros -> no tx_out, stays LISTEN.
- Request 32'hA2_F0_BEEF held 2 cycles -> id_err=1, FAULT, tx_out never asserted.
- After adoption of ID 4, resend 32'hA7_34_BEEF 2 cycles -> re-ACK with data_out=32'h5_7_4_5_BEEF; 4th resend -> id_err=1, FAULT.
- After adoption, request 32'hA1_56_BEEF -> ignored, chip_id stays 4.
- With SORT_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=50, data_in=0 -> id_err=1 at cycle 50; en dropped mid-ACK -> IDLE next cycle, outputs 0.
